// File: rtl/vedic_mul_arbiter_pkg.sv
// Shared widths, defaults and small helpers for the shared vedic multiplier wrapper.
package vedic_mul_arbiter_pkg;

    localparam int unsigned VM_OPW      = 8;
    localparam int unsigned VM_PRODW    = 16;
    localparam int unsigned VM_CNTW     = 16;
    localparam int unsigned VM_NREQ_DEF = 4;
    localparam int unsigned VM_IDW_DEF  = 2;

    typedef logic [VM_OPW-1:0]   vm_op_t;
    typedef logic [VM_PRODW-1:0] vm_prod_t;
    typedef logic [VM_CNTW-1:0]  vm_cnt_t;

    // Round-robin successor of a granted index.
    function automatic int unsigned vm_next_ptr(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int best_d;
    int d;

    // Pick the valid request with the smallest forward distance from ptr.
    always_comb begin
        best_d = int'(NREQ);
        d      = 0;
        idx    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            d = (i + int'(NREQ) - int'(ptr)) % int'(NREQ);
            if (req[i] && (d < best_d)) begin
                best_d = d;
                idx    = IDW'(i);
            end
        end
        any = en && (best_d < int'(NREQ));
    end

    // Decode the winning index to a one-hot grant.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            gnt[i] = any && (idx == IDW'(i));
        end
    end

endmodule

// File: rtl/vedic8x8.sv
// Combinational 8x8 unsigned multiplier built Urdhva-style from 2x2 and 4x4 vedic blocks.
module vedic8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // 2x2 vedic cell: vertical and crosswise partial products with a single carry.
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic       cross0;
        logic       cross1;
        logic       c;
        logic [3:0] r;
        cross0 = x[1] & y[0];
        cross1 = x[0] & y[1];
        c      = cross0 & cross1;
        r[0]   = x[0] & y[0];
        r[1]   = cross0 ^ cross1;
        r[2]   = (x[1] & y[1]) ^ c;
        r[3]   = (x[1] & y[1]) & c;
        return r;
    endfunction

    // 4x4 from four 2x2 cells; the two crosswise terms share the same weight.
    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] q_ll;
        logic [7:0] q_hl;
        logic [7:0] q_lh;
        logic [7:0] q_hh;
        q_ll = 8'(mul2(x[1:0], y[1:0]));
        q_hl = 8'(mul2(x[3:2], y[1:0]));
        q_lh = 8'(mul2(x[1:0], y[3:2]));
        q_hh = 8'(mul2(x[3:2], y[3:2]));
        return q_ll + (q_hl << 2) + (q_lh << 2) + (q_hh << 4);
    endfunction

    logic [15:0] pp_ll;
    logic [15:0] pp_hl;
    logic [15:0] pp_lh;
    logic [15:0] pp_hh;

    // 8x8 from four 4x4 blocks, summed at their vertical/crosswise weights.
    always_comb begin
        pp_ll = 16'(mul4(a[3:0], b[3:0]));
        pp_hl = 16'(mul4(a[7:4], b[3:0]));
        pp_lh = 16'(mul4(a[3:0], b[7:4]));
        pp_hh = 16'(mul4(a[7:4], b[7:4]));
        p     = pp_ll + (pp_hl << 4) + (pp_lh << 4) + (pp_hh << 8);
    end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shares one vedic8x8 between NREQ requesters through a two-stage elastic pipeline.
module vedic_mul_arbiter
    import vedic_mul_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = VM_NREQ_DEF,
    parameter int unsigned IDW  = VM_IDW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [VM_OPW*NREQ-1:0] req_a,
    input  logic [VM_OPW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [VM_PRODW-1:0]    rsp_prod,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy,
    output logic [VM_CNTW-1:0]     ops_done
);

    logic           s1_vld;
    vm_op_t         s1_a;
    vm_op_t         s1_b;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] rr_ptr;

    logic           s2_adv;
    logic           s1_load;
    logic           arb_en;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    vm_op_t         sel_a;
    vm_op_t         sel_b;
    vm_prod_t       mul_p;

    assign s2_adv  = !rsp_valid || rsp_ready;
    assign s1_load = !s1_vld || s2_adv;
    // Gate with rst_n so no grant is shown while reset is held.
    assign arb_en  = s1_load && rst_n;
    assign busy    = s1_vld || rsp_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (req_ready),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Operand mux driven by the one-hot grant (OR of masked lanes).
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_a = sel_a | req_a[i*VM_OPW +: VM_OPW];
                sel_b = sel_b | req_b[i*VM_OPW +: VM_OPW];
            end
        end
    end

    vedic8x8 u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (mul_p)
    );

    // Stage S1: capture the granted operands, or empty when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
        end else if (s1_load) begin
            s1_vld <= gnt_any;
            if (gnt_any) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= gnt_idx;
            end
        end
    end

    // Stage S2: register the product; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_prod  <= '0;
            rsp_id    <= '0;
        end else if (s2_adv) begin
            rsp_valid <= s1_vld;
            rsp_prod  <= mul_p;
            rsp_id    <= s1_id;
        end
    end

    // Round-robin pointer moves just past the most recent winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= IDW'(vm_next_ptr(32'(gnt_idx), NREQ));
        end
    end

    // Saturating count of completed response transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (rsp_valid && rsp_ready && (ops_done != {VM_CNTW{1'b1}})) begin
            ops_done <= ops_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Scoreboard bench: predictor pushes expected products, monitor pops on each response.
module tb_vedic_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [15:0]       rsp_prod;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    logic [15:0]       ops_done;

    vedic_mul_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int prod;
        int id;
        int c;
    } exp_t;

    int              checks = 0;
    int              failures = 0;
    exp_t            exp_q[$];
    logic [15:0]     src_q[NREQ][$];
    int              gnt_log[$];
    int              cyc = 0;
    int              ptr_m = 0;
    int              ops_m = 0;
    logic [NREQ-1:0] last_xfer = '0;
    int              last_prod = -1;
    int              last_id = -1;
    bit              rand_ready = 0;
    logic            rsp_ready_fix = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit pend();
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1;
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: each requester presents the head of its queue until it transfers.
    always @(posedge clk) begin
        logic [15:0] e;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (last_xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                e = src_q[i][0];
                req_valid[i] = 1'b1;
                req_a[8*i +: 8] = e[15:8];
                req_b[8*i +: 8] = e[7:0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : rsp_ready_fix;
    end

    // Monitor: response side of a depth-2 buffer, checked against the scoreboard.
    always @(negedge clk) begin
        bit ev;
        exp_t h;
        if (rst_n) begin
            ev = 0;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                ev = (h.c < cyc);
            end
            check("rsp_valid", 32'(rsp_valid), 32'(ev));
            check("busy", 32'(busy), 32'(exp_q.size() > 0));
            check("ops_done", 32'(ops_done), 32'(ops_m));
            if (ev) begin
                check("rsp_prod", 32'(rsp_prod), 32'(h.prod));
                check("rsp_id", 32'(rsp_id), 32'(h.id));
                if (rsp_ready) begin
                    last_prod = h.prod;
                    last_id = h.id;
                    void'(exp_q.pop_front());
                    if (ops_m < 65535) ops_m++;
                end
            end
        end
    end

    // Predictor: accept while fewer than two ops are held; round-robin from ptr_m.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        int w;
        int j;
        exp_t n;
        #1;
        eg = '0;
        w = -1;
        if (!rst_n) begin
            check("req_ready_in_reset", 32'(req_ready), 32'(0));
            last_xfer = '0;
        end else begin
            if (exp_q.size() < 2) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (ptr_m + k) % NREQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
            end
            if (w >= 0) eg[w] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(eg));
            last_xfer = req_valid & req_ready;
            if (w >= 0) begin
                n.prod = int'(req_a[8*w +: 8]) * int'(req_b[8*w +: 8]);
                n.id = w;
                n.c = cyc + 1;
                exp_q.push_back(n);
                gnt_log.push_back(w);
                ptr_m = (w + 1) % NREQ;
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((exp_q.size() > 0 || pend()) && n < bound) begin
            @(posedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < bound), 32'(1));
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_ops_done", 32'(ops_done), 32'(0));
        check("reset_rsp_prod", 32'(rsp_prod), 32'(0));
        exp_q.delete();
        ptr_m = 0;
        ops_m = 0;
        last_xfer = '0;
        repeat (hold) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int lowest;
        // Reset state, with a request already waiting on req0.
        src_q[0].push_back(16'hFFFF);
        repeat (3) @(posedge clk);
        #2;
        check("init_rsp_valid", 32'(rsp_valid), 32'(0));
        check("init_ops_done", 32'(ops_done), 32'(0));
        check("init_rsp_id", 32'(rsp_id), 32'(0));
        rst_n = 1'b1;

        // Single op 0xFF*0xFF.
        wait_idle(20);
        check("single_ops_done", 32'(ops_done), 32'(1));
        check("single_prod", 32'(last_prod), 32'(16'hFE01));
        check("single_id", 32'(last_id), 32'(0));

        // Round robin with all four requesters streaming.
        do_reset(2);
        gnt_log.delete();
        @(posedge clk);
        for (int r = 0; r < 2; r++) begin
            src_q[0].push_back(16'h0F11);
            src_q[1].push_back(16'h8002);
            src_q[2].push_back(16'hA55A);
            src_q[3].push_back(16'h0037);
        end
        wait_idle(40);
        check("rr_count", 32'(gnt_log.size()), 32'(8));
        for (int k = 0; k < 5; k++) check("rr_order", 32'(gnt_log[k]), 32'(k % 4));
        check("rr_last_prod", 32'(last_prod), 32'(16'h0000));

        // Backpressure: only two ops fit while the consumer stalls.
        rsp_ready_fix = 1'b0;
        gnt_log.delete();
        @(posedge clk);
        for (int k = 0; k < 5; k++) src_q[1].push_back({8'(8'h10 + k), 8'h03});
        repeat (6) @(posedge clk);
        #2;
        check("bp_grants", 32'(gnt_log.size()), 32'(2));
        check("bp_req_ready", 32'(req_ready), 32'(0));
        repeat (3) @(posedge clk);
        #2;
        check("bp_hold_prod", 32'(rsp_prod), 32'(16'h0030));
        check("bp_hold_id", 32'(rsp_id), 32'(1));
        rsp_ready_fix = 1'b1;
        wait_idle(40);

        // Randomised traffic with random backpressure.
        rand_ready = 1;
        for (int t = 0; t < 1500; t++) begin
            @(posedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 2) == 0 && src_q[i].size() < 3) begin
                    src_q[i].push_back(16'($urandom));
                end
            end
        end
        rand_ready = 0;
        wait_idle(200);

        // Mid-operation reset with both stages full.
        rsp_ready_fix = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) src_q[0].push_back(16'h1234);
        for (int k = 0; k < 2; k++) src_q[3].push_back(16'h5678);
        repeat (4) @(posedge clk);
        lowest = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (src_q[i].size() > 0) lowest = i;
        gnt_log.delete();
        do_reset(2);
        rsp_ready_fix = 1'b1;
        wait_idle(40);
        check("post_reset_first_grant", 32'(gnt_log[0]), 32'(lowest));

        // Exhaustive operand sweep on req2; also drives ops_done into saturation.
        @(posedge clk);
        for (int v = 0; v < 65536; v++) src_q[2].push_back(16'(v));
        wait_idle(70000);
        check("ops_saturated", 32'(ops_done), 32'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vedic_mul_arbiter.md
# vedic_mul_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one `vedic8x8` combinational multiplier between `NREQ` independent requesters. Each requester presents an 8x8 unsigned operand pair over a valid/ready handshake. The block registers the winning operands, drives them through the shared multiplier, and returns the 16-bit product tagged with the requester index over a downstream valid/ready channel. It sits between DSP-side clients and the single multiplier instance, and sequences all traffic to it.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: width of the requester tag. Must satisfy 2^IDW ≥ NREQ.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input NREQ: per-requester operand valid.
- `req_a` input 8*NREQ: operand A. Requester i uses bits [8i+7:8i].
- `req_b` input 8*NREQ: operand B, same packing as `req_a`.
- `req_ready` output NREQ: one-hot grant. Transfer for requester i occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid` output 1: product valid.
- `rsp_ready` input 1: downstream accepts product.
- `rsp_prod` output 16: unsigned product a*b.
- `rsp_id` output IDW: index of the requester that issued the operation.
- `busy` output 1: high when either pipeline stage holds data.
- `ops_done` output 16: count of completed response transfers. Saturates at 0xFFFF.

## Operation
- **Stage S1 (operand register):** holds `s1_vld`, `s1_a`, `s1_b` and `s1_id`. These registers feed `vedic8x8` combinationally.
- **Stage S2 (result register):** holds `rsp_valid`, `rsp_prod` and `rsp_id`.
- **S2 advance:** `s2_adv = !rsp_valid | rsp_ready`.
  - When `s2_adv` is high, S2 loads the S1 contents: `rsp_valid <= s1_vld`.
- **S1 load condition:** `s1_load = !s1_vld | s2_adv`.
  - When `s1_load` is high, S1 loads the granted request if there is one. Otherwise `s1_vld <= 0`.
- **Arbitration:** round-robin pointer `rr_ptr` (IDW bits, reset 0).
  - Grant goes to the first i with `req_valid[i]`, scanning from `rr_ptr` upward modulo NREQ.
  - A grant is issued only when `s1_load` is high.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and `s1_load`. At most one bit is high.
  - After a grant to i, `rr_ptr <= (i+1) mod NREQ`. Without a grant, `rr_ptr` holds.
- **Requester rules:**
  - Once asserted, `req_valid[i]` and its operands must hold stable until the transfer completes.
  - `req_valid` must not depend on `req_ready`.
- **Response rules:** while `rsp_valid & !rsp_ready`, `rsp_prod` and `rsp_id` are held stable.
- **Counters and status:**
  - `ops_done` increments on each `rsp_valid & rsp_ready` and stops at 0xFFFF.
  - `busy = s1_vld | rsp_valid`.
- **Arithmetic:** product is the full 16-bit unsigned result; no truncation or rounding. 0x00 times any operand gives 0x0000.
- **Reset:**
  - Asserting `rst_n` low at any time, including mid-operation, immediately clears `s1_vld`, `rsp_valid`, `rr_ptr` and `ops_done` to 0. `rsp_prod` and `rsp_id` also clear to 0.
  - Any in-flight operations are discarded; no response is produced for them.
  - `req_ready` is 0 while reset is asserted.
- **Boundary conditions:**
  - Pipeline full and `rsp_ready` low: `req_ready` is all zero and no state changes.
  - S2 drains and S1 refills in the same cycle: both happen. This sustains full throughput.
  - All requesters valid continuously: grants rotate 0,1,2,3,0,... and no requester waits more than NREQ-1 grants.
  - Pointer wrap: a grant to index NREQ-1 returns `rr_ptr` to 0.

## Timing
- **Latency:** a request accepted at edge k produces `rsp_valid` high after edge k+1, so a response transfer is possible at edge k+2 at the earliest.
- **Throughput:** one operation per cycle when `rsp_ready` is held high.
- **Critical path:** the multiplier path runs from the S1 registers to the S2 registers only. There is no combinational path from `req_*` to `rsp_*`.
- **Combinational dependency:** `rsp_ready` feeds into `req_ready` through `s2_adv` and `s1_load`.
- **Reset release:** the first grant can occur at the first rising edge after `rst_n` deasserts.

## Structure
- **Shared package / include:** `VM_OPW = 8`, `VM_PRODW = 16`, `VM_CNTW = 16`, and the default NREQ and IDW values.
- **Sub-module:** `rr_arbiter`, parameterised by NREQ. Inputs are the request vector, pointer and enable; outputs are the one-hot grant and the encoded index. The multiplier is the existing `vedic8x8`, instantiated once.

## Test plan
- **Single op:** after reset, req0 sends a=0xFF, b=0xFF with `rsp_ready`=1. Expect `rsp_prod`=0xFE01, `rsp_id`=0 two edges after acceptance, and `ops_done`=1.
- **Round-robin:** all four requesters valid continuously, with operands a=0x0F, b=0x11; 0x80, 0x02; 0xA5, 0x5A; 0x00, 0x37. Expect grants in order 0,1,2,3,0. Expect products 0x00FF, 0x0100, 0x3A02, 0x0000 back-to-back, one per cycle.
- **Backpressure:** hold `rsp_ready`=0 with req1 streaming. Expect two operations accepted, then `req_ready`=0. `rsp_prod` stays stable until `rsp_ready`=1, then results drain in order.
- **Mid-operation reset:** pull `rst_n` low while both stages are full. Expect `rsp_valid`, `busy` and `ops_done` equal to 0 immediately. After release, no stale response appears and the first grant goes to the lowest valid index.
- **Exhaustive sweep:** all 65536 operand pairs on req2, checked against a*b with `rsp_id`=2.
- **Counter saturation:** force or run 65536 transfers. Expect `ops_done` to stay at 0xFFFF.
